pad_bus_ctrl: RTL and testbench

- Half-duplex sequencer for a DW-bit shared bidirectional bus built from bidirectional I/O pad cells (C/I/OEN/REN pins).
- Arbitrates between a core transmit requester and a core receive requester, and drives pad OEN and I.
- Inserts programmable turnaround cycles between driving and releasing the bus.
- Synchronizes pad C inputs and returns captured words to the core; sits between core logic and the pad ring.

---
 rtl/pad_bus_pkg.sv | 28 ++
 rtl/pad_bus_ctrl_if.sv | 26 ++
 rtl/pad_sync2.sv | 23 ++
 rtl/pad_bus_ctrl.sv | 129 ++++++++++++
 tb/tb_pad_bus_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pad_bus_pkg.sv
// Shared types and constants for the pad bus sequencer.
package pad_bus_pkg;

    localparam int DW_DEF       = 8;
    localparam int HOLD_CYC_DEF = 2;
    localparam int TURN_CYC_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        TURN,
        RX_WAIT,
        RX_CAP
    } state_t;

    typedef enum logic {
        TX,
        RX
    } grant_t;

    // Pad OEN is active low: OEN_OFF tristates the pad driver.
    localparam logic OEN_OFF = 1'b1;
    localparam logic OEN_ON  = 1'b0;
    // Pad REN is active low: REN_ON enables the keeper/pull.
    localparam logic REN_ON  = 1'b0;
    localparam logic REN_OFF = 1'b1;

endpackage

// File: rtl/pad_bus_ctrl_if.sv
// Core-side handshake plus pad-ring pins of the pad bus sequencer.
interface pad_bus_ctrl_if #(parameter int DW = pad_bus_pkg::DW_DEF);

    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_ready;
    logic          rx_req;
    logic          rx_valid;
    logic [DW-1:0] rx_data;
    logic [DW-1:0] pad_i;
    logic [DW-1:0] pad_oen;
    logic [DW-1:0] pad_c;
    logic [DW-1:0] pad_ren;
    logic          busy;

    modport master (
        output tx_valid, tx_data, rx_req, pad_c,
        input  tx_ready, rx_valid, rx_data, pad_i, pad_oen, pad_ren, busy
    );

    modport slave (
        input  tx_valid, tx_data, rx_req, pad_c,
        output tx_ready, rx_valid, rx_data, pad_i, pad_oen, pad_ren, busy
    );

endinterface

// File: rtl/pad_sync2.sv
// DW-wide two-flop synchronizer for asynchronous pad C inputs.
module pad_sync2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    logic [DW-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pad_bus_ctrl.sv
// Half-duplex pad bus sequencer: arbitrates core TX/RX, drives pad OEN/I with turnaround.
// Build option PAD_BUS_KEEPER_EN: pad pulls (REN low) enabled whenever the bus is not driven.
//
// state   | meaning
// IDLE    | bus released, arbitrating tx_valid vs rx_req
// DRIVE   | pads driven with the latched word, cnt counts hold cycles
// TURN    | bus released after a drive burst, requests ignored
// RX_WAIT | bus released, pad_c settling through the synchronizer
// RX_CAP  | rx_data/rx_valid presented for one cycle
module pad_bus_ctrl
    import pad_bus_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int HOLD_CYC = HOLD_CYC_DEF,
    parameter int TURN_CYC = TURN_CYC_DEF
) (
    input  logic            clk,
    input  logic            reset,
    pad_bus_ctrl_if.slave   bus
);

    localparam int CNT_MAX = (HOLD_CYC > TURN_CYC) ? HOLD_CYC : TURN_CYC;
    localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] TURN_LOAD = CW'(TURN_CYC - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    state_t        state, state_nx;
    grant_t        last_grant, grant_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          tx_rdy;
    logic [DW-1:0] pad_i_q;
    logic [DW-1:0] pad_oen_q;
    logic [DW-1:0] rx_data_q;
    logic          rx_valid_q;
    logic [DW-1:0] sync_q;

    pad_sync2 #(.DW(DW)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.pad_c),
        .q     (sync_q)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        grant_nx = last_grant;
        tx_rdy   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.tx_valid && (!bus.rx_req || last_grant == RX)) begin
                    tx_rdy   = 1'b1;
                    grant_nx = TX;
                    state_nx = DRIVE;
                    cnt_nx   = HOLD_LOAD;
                end else if (bus.rx_req) begin
                    grant_nx = RX;
                    state_nx = RX_WAIT;
                    cnt_nx   = ONE;
                end
            end
            DRIVE: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - ONE;
                end else if (bus.tx_valid && !bus.rx_req) begin
                    // chain the next word without releasing the bus
                    tx_rdy   = 1'b1;
                    grant_nx = TX;
                    cnt_nx   = HOLD_LOAD;
                end else begin
                    state_nx = TURN;
                    cnt_nx   = TURN_LOAD;
                end
            end
            TURN: begin
                if (cnt != '0) cnt_nx = cnt - ONE;
                else           state_nx = IDLE;
            end
            RX_WAIT: begin
                if (cnt != '0) cnt_nx = cnt - ONE;
                else           state_nx = RX_CAP;
            end
            RX_CAP:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= RX;
            pad_i_q    <= '0;
            pad_oen_q  <= {DW{OEN_OFF}};
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            last_grant <= grant_nx;
            if (tx_rdy) pad_i_q <= bus.tx_data;
            pad_oen_q  <= (state_nx == DRIVE) ? {DW{OEN_ON}} : {DW{OEN_OFF}};
            rx_valid_q <= (state_nx == RX_CAP);
            if (state_nx == RX_CAP) rx_data_q <= sync_q;
        end
    end

`ifdef PAD_BUS_KEEPER_EN
    logic [DW-1:0] pad_ren_q;

    always_ff @(posedge clk) begin
        if (reset) pad_ren_q <= {DW{REN_ON}};
        else       pad_ren_q <= (state_nx == DRIVE) ? {DW{REN_OFF}} : {DW{REN_ON}};
    end

    assign bus.pad_ren = pad_ren_q;
`else
    assign bus.pad_ren = {DW{REN_OFF}};
`endif

    assign bus.tx_ready = tx_rdy & ~reset;
    assign bus.pad_i    = pad_i_q;
    assign bus.pad_oen  = pad_oen_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_pad_bus_ctrl.sv
// Scoreboard bench for pad_bus_ctrl: directed scenarios then randomized traffic.
module tb_pad_bus_ctrl;

    localparam int DW     = 8;
    localparam int HOLD_N = 2;
    localparam int TURN_N = 2;
    localparam logic [DW-1:0] ALL1 = '1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pad_bus_ctrl_if #(.DW(DW)) bus ();

    pad_bus_ctrl #(.DW(DW), .HOLD_CYC(HOLD_N), .TURN_CYC(TURN_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] tx_exp_q[$];
    int            tx_cyc_q[$];
    logic [DW-1:0] rx_exp_q[$];
    int            rx_cyc_q[$];
    bit            grant_log[$];

    bit rx_pending    = 1'b0;
    bit model_last_rx = 1'b1;
    bit rst_d         = 1'b1;
    bit was_drive     = 1'b0;
    bit want_idle     = 1'b0;
    int drive_n       = 0;
    int turn_left     = 0;
    int last_drive    = -100;
    logic [DW-1:0] cur_word = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pad bursts, turnaround, captures and arbitration against the model.
    always @(negedge clk) begin
        logic [DW-1:0] ren_exp;
        bit drv;
        bit exp_tx;
        if (reset) begin
            chk("ready_in_reset", 32'(bus.tx_ready), 0);
            tx_exp_q.delete();
            tx_cyc_q.delete();
            rx_exp_q.delete();
            rx_cyc_q.delete();
            grant_log.delete();
            rx_pending    = 1'b0;
            model_last_rx = 1'b1;
            drive_n       = 0;
            turn_left     = 0;
            want_idle     = 1'b0;
            was_drive     = 1'b0;
            last_drive    = -100;
        end else begin
            drv = (bus.pad_oen == '0);
            if (rst_d) begin
                chk("rst_oen", 32'(bus.pad_oen), 32'(ALL1));
                chk("rst_pad_i", 32'(bus.pad_i), 0);
                chk("rst_rx_valid", 32'(bus.rx_valid), 0);
                chk("rst_rx_data", 32'(bus.rx_data), 0);
                chk("rst_busy", 32'(bus.busy), 0);
            end
`ifdef PAD_BUS_KEEPER_EN
            ren_exp = drv ? ALL1 : '0;
`else
            ren_exp = ALL1;
`endif
            chk("pad_ren", 32'(bus.pad_ren), 32'(ren_exp));
            chk("oen_uniform", 32'(drv || bus.pad_oen == ALL1), 1);

            if (want_idle) begin
                chk("idle_after_turn", 32'(bus.busy), 0);
                want_idle = 1'b0;
            end
            if (drv) begin
                last_drive = cyc;
                chk("drive_during_turn", 32'(turn_left), 0);
                if (drive_n == 0) begin
                    chk("burst_pending", 32'(tx_exp_q.size()), 1);
                    if (tx_exp_q.size() > 0) begin
                        cur_word = tx_exp_q.pop_front();
                        chk("burst_start_cycle", 32'(cyc), 32'(tx_cyc_q.pop_front()));
                    end
                end
                chk("pad_i", 32'(bus.pad_i), 32'(cur_word));
                drive_n = (drive_n + 1) % HOLD_N;
            end else begin
                if (was_drive) begin
                    chk("hold_length", 32'(drive_n), 0);
                    drive_n   = 0;
                    turn_left = TURN_N;
                end
                if (turn_left > 0) begin
                    chk("turn_busy", 32'(bus.busy), 1);
                    chk("turn_pad_i", 32'(bus.pad_i), 32'(cur_word));
                    turn_left--;
                    want_idle = (turn_left == 0);
                end
            end

            if (bus.rx_valid) begin
                chk("rx_expected", 32'(rx_exp_q.size()), 1);
                if (rx_exp_q.size() > 0) begin
                    chk("rx_data", 32'(bus.rx_data), 32'(rx_exp_q.pop_front()));
                    chk("rx_cycle", 32'(cyc), 32'(rx_cyc_q.pop_front()));
                end
                chk("rx_gap_after_drive", 32'(cyc - last_drive >= TURN_N + 3), 1);
                rx_pending = 1'b0;
            end

            if (!bus.busy) begin
                if (bus.tx_valid || bus.rx_req) begin
                    exp_tx = bus.tx_valid && (!bus.rx_req || model_last_rx);
                    chk("grant", 32'(bus.tx_ready), 32'(exp_tx));
                    grant_log.push_back(bus.tx_ready);
                    model_last_rx = !exp_tx;
                    if (!exp_tx) begin
                        rx_exp_q.push_back(bus.pad_c);
                        rx_cyc_q.push_back(cyc + 3);
                        rx_pending = 1'b1;
                    end
                end else begin
                    chk("idle_ready", 32'(bus.tx_ready), 0);
                end
            end else if (drv && drive_n == 0) begin
                chk("chain_ready", 32'(bus.tx_ready), 32'(bus.tx_valid && !bus.rx_req));
            end else begin
                chk("busy_ready", 32'(bus.tx_ready), 0);
            end
            if (bus.tx_valid && bus.tx_ready) begin
                tx_exp_q.push_back(bus.tx_data);
                tx_cyc_q.push_back(cyc + 1);
            end
            was_drive = drv;
        end
        rst_d = reset;
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = !bus.busy;
        end
        chk("reach_idle", 32'(ok), 1);
        step();
    endtask

    task automatic send(input logic [DW-1:0] w, input bit keep_valid);
        bit ok = 1'b0;
        bus.tx_data  = w;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus.tx_ready;
        end
        chk("tx_accept", 32'(ok), 1);
        step();
        if (!keep_valid) bus.tx_valid = 1'b0;
    endtask

    task automatic recv(input logic [DW-1:0] c, input bit hold_req);
        bit ok = 1'b0;
        bus.pad_c  = c;
        bus.rx_req = 1'b1;
        if (!hold_req) begin
            step();
            bus.rx_req = 1'b0;
        end
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus.rx_valid;
        end
        chk("rx_arrives", 32'(ok), 1);
        step();
        bus.rx_req = 1'b0;
    endtask

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        bus.rx_req   = 1'b0;
        bus.pad_c    = '0;
        reset        = 1'b1;
        repeat (3) step();
        reset = 1'b0;

        // Contention straight out of reset: TX, RX, TX.
        bus.pad_c    = 8'hC3;
        bus.tx_data  = 8'h77;
        bus.tx_valid = 1'b1;
        bus.rx_req   = 1'b1;
        repeat (20) step();
        bus.tx_valid = 1'b0;
        bus.rx_req   = 1'b0;
        wait_idle();
        chk("contention_grants", 32'(grant_log.size() >= 3), 1);
        if (grant_log.size() >= 3) begin
            chk("grant_order_0", 32'(grant_log[0]), 1);
            chk("grant_order_1", 32'(grant_log[1]), 0);
            chk("grant_order_2", 32'(grant_log[2]), 1);
        end

        send(8'hA5, 1'b0);
        wait_idle();
        send(8'h11, 1'b1);
        send(8'h22, 1'b0);
        wait_idle();
        recv(8'h3C, 1'b1);
        wait_idle();
        recv(8'h96, 1'b0);
        wait_idle();

        // Reset in the second hold cycle: the word must not reappear.
        send(8'h5A, 1'b0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (8) step();

        // Reset while waiting on a capture: no rx_valid may follow.
        bus.pad_c  = 8'h0F;
        bus.rx_req = 1'b1;
        step();
        bus.rx_req = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (8) step();

        for (int i = 0; i < 800; i++) begin
            bit acc;
            @(negedge clk);
            acc = bus.tx_valid && bus.tx_ready;
            step();
            if (!bus.tx_valid || acc) begin
                bus.tx_valid = ($urandom_range(0, 2) != 0);
                bus.tx_data  = DW'($urandom);
            end
            if ($urandom_range(0, 3) == 0) bus.rx_req = !bus.rx_req;
            if (!bus.rx_req && !rx_pending && $urandom_range(0, 1) == 1) bus.pad_c = DW'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
        end

        bus.tx_valid = 1'b0;
        bus.rx_req   = 1'b0;
        wait_idle();
        repeat (5) step();
        chk("tx_leftover", 32'(tx_exp_q.size()), 0);
        chk("rx_leftover", 32'(rx_exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: run exceeded time limit, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
